// File: rtl/and_serial_pkg_amisha.sv
// rtl/and_serial_pkg_amisha.sv - shared FSM states and index-width helper for the serial AND reducer
package and_serial_pkg_amisha;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    function automatic int idx_width(input int n_bits);
        return (n_bits < 2) ? 1 : $clog2(n_bits);
    endfunction

endpackage

// File: rtl/and_serial_reduce_amisha_bit_counter.sv
// rtl/and_serial_reduce_amisha_bit_counter.sv - wrapping modulo-N bit counter with enable and last-bit flag
module bit_counter_amisha #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last = (cnt_q == W'(N - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/and_serial_reduce_amisha.sv
// rtl/and_serial_reduce_amisha.sv - bit-serial AND reducer with first-zero index; AND_EARLY_EXIT_EN enables early result
module and_serial_reduce_amisha
    import and_serial_pkg_amisha::*;
#(
    parameter int N_BITS = 8
) (
    input  logic                        clk_amisha,
    input  logic                        rst_n_amisha,
    input  logic                        s_valid_amisha,
    output logic                        s_ready_amisha,
    input  logic                        s_bit_amisha,
    output logic                        m_valid_amisha,
    input  logic                        m_ready_amisha,
    output logic                        m_y_amisha,
    output logic [$clog2(N_BITS)-1:0]   m_zero_idx_amisha
);

    localparam int W = idx_width(N_BITS);

    state_t         state_q, state_d;
    logic           acc_q, acc_d;
    logic           seen0_q, seen0_d;
    logic [W-1:0]   zidx_q, zidx_d;
    logic           s_ready_q, s_ready_d;
    logic           m_valid_q, m_valid_d;
    logic           m_y_q, m_y_d;
    logic [W-1:0]   m_zero_idx_q, m_zero_idx_d;

    logic           accept;
    logic [W-1:0]   cnt;
    logic           cnt_last;

    assign accept = s_valid_amisha & s_ready_q;

    bit_counter_amisha #(.N(N_BITS), .W(W)) u_cnt (
        .clk   (clk_amisha),
        .rst_n (rst_n_amisha),
        .en    (accept),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        seen0_d      = seen0_q;
        zidx_d       = zidx_q;
        s_ready_d    = s_ready_q;
        m_valid_d    = m_valid_q;
        m_y_d        = m_y_q;
        m_zero_idx_d = m_zero_idx_q;

        if (accept) begin
            acc_d = acc_q & s_bit_amisha;
            if (!s_bit_amisha && !seen0_q) begin
                zidx_d  = cnt;
                seen0_d = 1'b1;
            end
        end

        case (state_q)
            ST_ACC: begin
                s_ready_d = 1'b1;
                if (accept && cnt_last) begin
                    state_d      = ST_RESULT;
                    s_ready_d    = 1'b0;
                    m_valid_d    = 1'b1;
                    m_y_d        = acc_d;
                    m_zero_idx_d = zidx_d;
                end
`ifdef AND_EARLY_EXIT_EN
                else if (accept && !s_bit_amisha && !seen0_q) begin
                    state_d      = ST_DRAIN;
                    m_valid_d    = 1'b1;
                    m_y_d        = 1'b0;
                    m_zero_idx_d = cnt;
                end
`endif
            end
            ST_RESULT: begin
                if (m_ready_amisha) begin
                    state_d   = ST_ACC;
                    s_ready_d = 1'b1;
                    m_valid_d = 1'b0;
                    acc_d     = 1'b1;
                    seen0_d   = 1'b0;
                    zidx_d    = '0;
                end
            end
`ifdef AND_EARLY_EXIT_EN
            // Result may already be out; the frame closes only once its last bit is consumed.
            ST_DRAIN: begin
                if (accept && cnt_last) begin
                    if (!m_valid_q || m_ready_amisha) begin
                        state_d   = ST_ACC;
                        m_valid_d = 1'b0;
                        acc_d     = 1'b1;
                        seen0_d   = 1'b0;
                        zidx_d    = '0;
                    end else begin
                        state_d   = ST_RESULT;
                        s_ready_d = 1'b0;
                    end
                end else if (m_valid_q && m_ready_amisha) begin
                    m_valid_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_q      <= ST_ACC;
            acc_q        <= 1'b1;
            seen0_q      <= 1'b0;
            zidx_q       <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_y_q        <= 1'b0;
            m_zero_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            seen0_q      <= seen0_d;
            zidx_q       <= zidx_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_y_q        <= m_y_d;
            m_zero_idx_q <= m_zero_idx_d;
        end
    end

    assign s_ready_amisha    = s_ready_q;
    assign m_valid_amisha    = m_valid_q;
    assign m_y_amisha        = m_y_q;
    assign m_zero_idx_amisha = m_zero_idx_q;

endmodule

// File: tb/tb_and_serial_reduce_amisha.sv
// tb/tb_and_serial_reduce_amisha.sv - self-checking bench for and_serial_reduce_amisha (default build, N_BITS=8)
module tb_and_serial_reduce_amisha;

    localparam int N = 8;

    typedef struct {
        logic       y;
        logic [2:0] idx;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n, s_valid, s_ready, s_bit, m_valid, m_ready, m_y;
    logic [2:0] m_zero_idx;

    int checks = 0;
    int errors = 0;

    res_t exp_q[$];
    res_t got_q[$];
    logic [N-1:0] frame_bits;
    int   nbits = 0;
    logic lat_due = 1'b0;

    and_serial_reduce_amisha #(.N_BITS(N)) dut (
        .clk_amisha        (clk),
        .rst_n_amisha      (rst_n),
        .s_valid_amisha    (s_valid),
        .s_ready_amisha    (s_ready),
        .s_bit_amisha      (s_bit),
        .m_valid_amisha    (m_valid),
        .m_ready_amisha    (m_ready),
        .m_y_amisha        (m_y),
        .m_zero_idx_amisha (m_zero_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic res_t model(input logic [N-1:0] bits);
        res_t r;
        r.y   = (bits == {N{1'b1}});
        r.idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!bits[i]) r.idx = 3'(i);
        end
        return r;
    endfunction

    // Model + per-cycle compare; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            nbits   = 0;
            lat_due = 1'b0;
            exp_q.delete();
        end else begin
            if (lat_due) chk("latency_m_valid", int'(m_valid), 1);
            lat_due = 1'b0;
            if (m_valid) begin
                chk("ready_valid_exclusive", int'(s_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 1, 0);
                end else begin
                    chk("m_y", int'(m_y), int'(exp_q[0].y));
                    chk("m_zero_idx", int'(m_zero_idx), int'(exp_q[0].idx));
                    if (m_ready) begin
                        res_t g;
                        g.y = m_y;
                        g.idx = m_zero_idx;
                        got_q.push_back(g);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (s_valid && s_ready) begin
                frame_bits[nbits] = s_bit;
                nbits++;
                if (nbits == N) begin
                    exp_q.push_back(model(frame_bits));
                    nbits   = 0;
                    lat_due = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [N-1:0] bits, input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            int budget = 0;
            logic ok;
            repeat (gap) begin
                s_valid = 1'b0;
                step();
            end
            s_valid = 1'b1;
            s_bit   = bits[i];
            do begin
                @(negedge clk);
                ok = s_ready && rst_n;
                step();
                budget++;
            end while (!ok && budget < 200);
            if (!ok) chk("send_timeout", budget, 0);
        end
        s_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic y, input logic [2:0] idx);
        int budget = 0;
        while (got_q.size() == 0 && budget < 200) begin
            step();
            budget++;
        end
        if (got_q.size() == 0) begin
            chk({name, "_timeout"}, budget, 0);
        end else begin
            res_t g = got_q.pop_front();
            chk({name, "_y"}, int'(g.y), int'(y));
            chk({name, "_idx"}, int'(g.idx), int'(idx));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_y", int'(m_y), 0);
        chk("rst_m_zero_idx", int'(m_zero_idx), 0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("s_ready_after_release", int'(s_ready), 1);
        step();

        send_bits(8'hFF, N, 0);
        expect_result("all_ones", 1'b1, 3'd0);
        send_bits(8'hF7, N, 0);
        expect_result("bit3_zero", 1'b0, 3'd3);
        send_bits(8'hDB, N, 0);
        expect_result("bits2_5_zero", 1'b0, 3'd2);

        m_ready = 1'b0;
        send_bits(8'h7F, N, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_s_ready", int'(s_ready), 0);
            chk("bp_m_valid", int'(m_valid), 1);
            step();
        end
        m_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_next_frame_ready", int'(s_ready), 1);
        step();
        expect_result("bp_bit7_zero", 1'b0, 3'd7);

        send_bits(8'hFF, 5, 0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", int'(m_valid), 0);
            step();
        end
        chk("mid_rst_no_result", got_q.size(), 0);
        send_bits(8'hFF, N, 0);
        expect_result("post_rst_ones", 1'b1, 3'd0);

        send_bits(8'hFF, N, 3);
        send_bits(8'hFE, N, 3);
        send_bits(8'h7F, N, 3);
        expect_result("gap_f1", 1'b1, 3'd0);
        expect_result("gap_f2", 1'b0, 3'd0);
        expect_result("gap_f3", 1'b0, 3'd7);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/and_serial_reduce_amisha.md
# and_serial_reduce_amisha

Sequential AND reducer that consumes an operand one bit per handshake and returns the AND of an `N_BITS`-bit frame, plus the position of the first zero bit. It is the bit-serial counterpart of the team's combinational AND blocks. It sits between a serial bit source (valid/ready) and a result consumer (valid/ready). One result is produced per frame.

## Interface
- `N_BITS`, default 8: bits per frame; legal range 2..256.
- `clk_amisha`, in, 1: clock; all state changes on the rising edge.
- `rst_n_amisha`, in, 1: reset, synchronous, active-low.
- `s_valid_amisha`, in, 1: input bit valid.
- `s_ready_amisha`, out, 1: block accepts a bit this cycle.
- `s_bit_amisha`, in, 1: operand bit; frame bit 0 arrives first.
- `m_valid_amisha`, out, 1: result valid.
- `m_ready_amisha`, in, 1: consumer takes the result.
- `m_y_amisha`, out, 1: AND of all frame bits.
- `m_zero_idx_amisha`, out, `$clog2(N_BITS)`: index of the first 0 bit; 0 when `m_y_amisha`=1.

## Operation
- Input transfer happens when `s_valid & s_ready`. Output transfer happens when `m_valid & m_ready`.
- Registered state:
  - `acc`: 1 bit, preset to 1 at frame start.
  - `cnt`: `$clog2(N_BITS)` bits, counts 0..N_BITS-1.
  - `zidx`: first-zero index.
  - `seen0`: flag, set once a zero has been captured.
- On each accepted bit:
  - `acc <= acc & bit`.
  - If `bit`=0 and not `seen0`: `zidx <= cnt` and `seen0 <= 1`.
  - `cnt` increments. When `cnt`=N_BITS-1 it wraps to 0, which ends the frame.
- FSM states:
  - ACC: `s_ready`=1, `m_valid`=0. When the last bit is accepted, the result registers load and the FSM goes to RESULT.
  - RESULT: `s_ready`=0, `m_valid`=1. Outputs are held stable until `m_ready`. Then `acc`, `seen0` and `zidx` are cleared to frame-start values and the FSM returns to ACC.
  - DRAIN: exists only with `AND_EARLY_EXIT_EN` (see Configuration).
- Outputs come straight from registers. No combinational path from input to output.
- Reset values:
  - FSM = ACC.
  - `s_ready` = 1 from the first cycle after reset release; 0 while reset is asserted.
  - `m_valid`, `m_y`, `m_zero_idx` = 0; `cnt` = 0; `acc` = 1.
- Reset mid-frame discards the partial frame and any pending result. No result is emitted for it.
- `s_valid` while `s_ready`=0 is ignored. The source holds the bit until it is accepted.

## Timing
- Latency: `m_valid` rises on the cycle after the edge that accepts bit N_BITS-1.
- Throughput without the macro: N_BITS+1 cycles per frame minimum. This means N_BITS bit cycles plus one RESULT cycle, with `m_ready` tied high.
- `m_ready` asserted in the first RESULT cycle: `s_ready` is high again on the next cycle.
- Backpressure on the output stalls the input indefinitely. No bits are dropped.
- Gaps in `s_valid` stall `cnt`. The frame stays open for any number of idle cycles.

## Configuration
- Macro `AND_EARLY_EXIT_EN`.
- Undefined: the result appears only after all N_BITS bits. DRAIN is not synthesized.
- Defined, when a 0 bit is accepted at index i < N_BITS-1 with `seen0`=0:
  - The FSM goes to DRAIN. `m_valid`=1 on the next cycle with `m_y`=0 and `m_zero_idx`=i.
  - `s_ready` stays 1, and the remaining bits are consumed and discarded by the AND.
  - DRAIN exits are decided in the same cycle:
    - Result taken and last bit accepted: go to ACC.
    - Result taken first: stay in DRAIN with `m_valid`=0 until the last bit, then go to ACC.
    - Last bit first: go to RESULT.
  - The next frame never starts before the current frame's bits are fully drained.
  - A 0 at index N_BITS-1 behaves as in the undefined build.

## Structure
- Package `and_serial_pkg_amisha` holds:
  - the FSM state enum (ACC, DRAIN, RESULT);
  - a function returning the index width for a given N_BITS.
- One sub-module is natural: `bit_counter_amisha`, a wrapping modulo-N counter with enable, providing `cnt` and a last-bit flag.

## Test plan
- N_BITS=8, frame 1111_1111, `m_ready`=1 → `m_y`=1, `m_zero_idx`=0, `m_valid` 1 cycle after the 8th bit.
- N_BITS=8, frame with bit 3 = 0, others 1 → `m_y`=0, `m_zero_idx`=3. With `AND_EARLY_EXIT_EN`, `m_valid` rises the cycle after bit 3 and the 4 remaining bits are still accepted.
- Bits 2 and 5 = 0 → `m_zero_idx`=2, never 5.
- `m_ready`=0 for 10 cycles in RESULT → `s_ready`=0 and outputs stable throughout. The next frame starts 1 cycle after `m_ready`.
- Reset low after bit 4 → no `m_valid`. The following 8-bit all-ones frame gives `m_y`=1.
- Random `s_valid` gaps across 3 back-to-back frames (1s; bit 0 = 0; bit 7 = 0) → results 1/0, 0/0, 0/7 in order.
